// File: rtl/exp_accel_arbiter_pkg.sv
// rtl/exp_accel_arbiter_pkg.sv - shared types, widths and defaults for the accelerator arbiter
package exp_accel_arbiter_pkg;

    localparam int VI_W  = 5;
    localparam int UI_W  = 2;
    localparam int RES_W = 21;

    localparam int START_CYCLES_DEF   = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/exp_accel_arbiter_rr_arb2.sv
// rtl/exp_accel_arbiter_rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // last is the index granted most recently; the other requester wins a tie
    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/exp_accel_arbiter.sv
// rtl/exp_accel_arbiter.sv - arbitrates two requesters onto one accelerator, forwards results, watchdog abort
module exp_accel_arbiter
    import exp_accel_arbiter_pkg::*;
#(
    parameter int START_CYCLES   = START_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [VI_W-1:0]  req0_vi,
    input  logic [VI_W-1:0]  req1_vi,
    input  logic [UI_W-1:0]  req0_ui,
    input  logic [UI_W-1:0]  req1_ui,
    output logic             acc_start,
    output logic [VI_W-1:0]  acc_vi,
    output logic [UI_W-1:0]  acc_ui,
    input  logic             acc_done,
    input  logic             acc_wr_req,
    input  logic [RES_W-1:0] acc_wr_data,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic             res_id,
    output logic             job_done,
    output logic             job_err,
    output logic             job_id,
    output logic             busy
);

    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT_CYCLES);

    state_t          state;
    state_t          state_d;
    logic [1:0]      grant;
    logic            rr_last;
    logic            owner;
    logic            done_q;
    logic [SC_W-1:0] start_cnt;
    logic [WD_W-1:0] wdog;
    logic            handshake;
    logic            start_done;
    logic            done_rise;
    logic            wd_expired;
    logic            beat;

    rr_arb2 u_rr_arb2 (
        .req   ({req1_valid, req0_valid}),
        .last  (rr_last),
        .grant (grant)
    );

    assign handshake  = req0_ready | req1_ready;
    assign start_done = (start_cnt == START_LAST);
    assign done_rise  = acc_done & ~done_q;
    assign wd_expired = (wdog == WD_LAST);
    assign beat       = acc_wr_req & (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (handshake) state_d = ST_START;
            ST_START: if (start_done) state_d = ST_WAIT;
            ST_WAIT:  if (done_rise || wd_expired) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        acc_start  = 1'b0;
        busy       = 1'b0;
        job_done   = 1'b0;
        job_err    = 1'b0;
        job_id     = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant[0] & ~rst;
                req1_ready = grant[1] & ~rst;
            end
            ST_START: begin
                acc_start = 1'b1;
                busy      = 1'b1;
            end
            ST_WAIT: begin
                busy     = 1'b1;
                // a completion edge wins over a watchdog expiry in the same cycle
                job_done = done_rise;
                job_err  = wd_expired & ~done_rise;
                job_id   = (done_rise | wd_expired) ? owner : 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            acc_vi    <= '0;
            acc_ui    <= '0;
            done_q    <= 1'b0;
            start_cnt <= '0;
            wdog      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            done_q <= acc_done;
            if (handshake) begin
                owner   <= grant[1];
                rr_last <= grant[1];
                acc_vi  <= grant[1] ? req1_vi : req0_vi;
                acc_ui  <= grant[1] ? req1_ui : req0_ui;
            end
            start_cnt <= (state == ST_START && !start_done) ? start_cnt + SC_W'(1) : '0;
            // zero everywhere outside WAIT, so it starts from 0 on WAIT entry
            if (state != ST_WAIT) begin
                wdog <= '0;
            end else if (wdog != WD_MAX) begin
                wdog <= wdog + WD_W'(1);
            end
            res_valid <= beat;
            if (beat) begin
                res_data <= acc_wr_data;
                res_id   <= owner;
            end
        end
    end

endmodule

// File: doc/exp_accel_arbiter.md
EXP_ACCEL_ARBITER -- requirements
Module: exp_accel_arbiter

Interface
REQ-001 The block SHALL have parameter START_CYCLES, default 2: number of cycles acc_start is held high per job.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles spent in WAIT before abort.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  requester has a job.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1  job accepted this cycle when valid&ready.
REQ-007 The block SHALL have ports req0_vi / req1_vi  input  5  vi operand, plus req0_ui / req1_ui  input  2  ui operand.
REQ-008 The block SHALL have ports acc_start  output  1, acc_vi  output  5, acc_ui  output  2: accelerator command.
REQ-009 The block SHALL have ports acc_done  input  1, acc_wr_req  input  1, acc_wr_data  input  21: accelerator status and result beats.
REQ-010 The block SHALL have ports res_valid  output  1, res_data  output  21, res_id  output  1: result beat tagged with owning requester.
REQ-011 The block SHALL have ports job_done  output  1, job_err  output  1, job_id  output  1, busy  output  1.

Function
REQ-012 FSM states SHALL be IDLE, START, WAIT; busy=1 in every state except IDLE.
REQ-013 In IDLE, the arbiter SHALL drive req_ready high for exactly one valid requester, chosen round-robin: the requester not granted last wins a tie.
REQ-014 With one requester valid, that requester SHALL be granted regardless of the round-robin pointer.
REQ-015 On handshake, the block SHALL latch vi, ui and owner id, update the round-robin pointer, and go to START.
REQ-016 Both req_ready SHALL be low in START and WAIT; no job is queued beyond the one in service.
REQ-017 In START, acc_start SHALL be high for exactly START_CYCLES cycles, then the FSM SHALL go to WAIT.
REQ-018 acc_vi and acc_ui SHALL hold the latched operands from START entry until IDLE is re-entered.
REQ-019 acc_vi and acc_ui SHALL hold their previous values in IDLE.
REQ-020 Completion SHALL be the acc_done rising edge, detected against a registered copy of acc_done.
REQ-021 A level high on acc_done that is already present on WAIT entry SHALL NOT count as completion.
REQ-022 On completion in WAIT, the block SHALL pulse job_done for one cycle with job_id = owner and return to IDLE.
REQ-023 A new grant SHALL be possible at the earliest on the cycle after job_done.
REQ-024 Each acc_wr_req beat seen in START or WAIT SHALL appear one cycle later as res_valid=1 with res_data = acc_wr_data and res_id = owner.
REQ-025 acc_wr_req in IDLE SHALL be ignored.
REQ-026 A wr_req beat coincident with completion SHALL still be forwarded.
REQ-027 A watchdog counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-028 When the watchdog reaches TIMEOUT_CYCLES without completion, the block SHALL pulse job_err for one cycle with job_id = owner and return to IDLE without job_done.
REQ-029 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-030 The watchdog counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL NOT wrap.
REQ-031 The START-phase counter SHALL be sized to START_CYCLES.

Reset
REQ-032 rst SHALL, in the same cycle it is sampled and from any state, force IDLE.
REQ-033 Reset SHALL clear acc_start, res_valid, job_done, job_err, busy, req0_ready, req1_ready, acc_vi, acc_ui, res_data, res_id, job_id and both counters to 0.
REQ-034 Reset SHALL set the round-robin pointer to "last granted = 1", so req0 wins the first tie.
REQ-035 A job in flight at reset SHALL be dropped with no job_done or job_err; later acc_done or acc_wr_req for it SHALL be handled per REQ-021 and REQ-025.

Structure
REQ-036 A shared package SHALL hold the state enum, operand widths (VI_W=5, UI_W=2, RES_W=21) and default parameter values.
REQ-037 The round-robin grant logic SHALL be a separate sub-module, rr_arb2, with inputs req[1:0] and the pointer, and outputs a one-hot grant; everything else stays in the top.

Verification
REQ-038 req0 vi=5'b01110 ui=2'b01 only -> req0_ready 1 cycle; acc_start high 2 cycles with acc_vi=01110, acc_ui=01; acc_done rise -> job_done, job_id=0.
REQ-039 req0 vi=11000 and req1 vi=10011 valid together after reset -> req0 served first, then req1; a further tie -> req0.
REQ-040 Model emits 3 acc_wr_req beats 0x00001, 0x0ABCD, 0x1FFFF in WAIT for req1's job -> 3 res_valid beats, same data, res_id=1, each 1 cycle later.
REQ-041 acc_done never rises, TIMEOUT_CYCLES=16 -> job_err at WAIT cycle 16, job_done stays 0, IDLE and ready on the next cycle.
REQ-042 acc_done held high from before START -> no completion until it falls and rises again.
REQ-043 rst pulsed mid-WAIT -> all outputs 0 next cycle; a later acc_done edge produces no job_done.
